uart_column_scheduler: RTL and testbench



---
 rtl/uart_column_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_uart_column_scheduler.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_column_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : uart_column_scheduler
// Brief    : Round-robin sequencer sharing one UART transmitter across the
//            columns of the result matrix; optional statistics outputs are
//            built when UART_COLUMN_SCHEDULER_STATS_EN is defined.
// Revision : 1.0  initial release
//==============================================================================
module uart_column_scheduler #(
    parameter  int COLUMNS    = 4,
    parameter  int ROWS       = 4,
    parameter  int FRAME_BITS = 11,
    parameter  int GAP_CYCLES = 2,
    localparam int c_ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                      uart_column_scheduler_clock,
    input  logic                      uart_column_scheduler_reset_active_low,
    input  logic [COLUMNS-1:0]        uart_column_scheduler_request,
    output logic [COLUMNS-1:0]        uart_column_scheduler_ack,
    output logic signed [31:0]        uart_column_scheduler_column,
    output logic [c_ROW_W-1:0]        uart_column_scheduler_row,
    output logic                      uart_column_scheduler_load,
    output logic                      uart_column_scheduler_enable,
    output logic                      uart_column_scheduler_busy
`ifdef UART_COLUMN_SCHEDULER_STATS_EN
    ,
    output logic [15:0]               uart_column_scheduler_frames_sent,
    output logic [15:0]               uart_column_scheduler_wait_max
`endif
);

    localparam int c_PTR_W = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
    localparam int c_BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(ROWS - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(COLUMNS - 1);
    localparam logic [COLUMNS-1:0] c_ACK_ONE  = COLUMNS'(1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SEND = 3'd2,
        ST_DONE = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    state_t               r_state;
    logic [COLUMNS-1:0]   r_ack;
    logic signed [31:0]   r_column;
    logic [c_ROW_W-1:0]   r_row;
    logic                 r_load;
    logic                 r_enable;
    logic                 r_busy;
    logic [c_PTR_W-1:0]   r_pointer;
    logic [c_BIT_W-1:0]   r_bit_count;
    logic [c_GAP_W-1:0]   r_gap_count;

    logic [c_PTR_W-1:0]   w_grant;
    logic [c_PTR_W-1:0]   w_idx;
    logic                 w_any_request;
    logic                 w_frame_end;
    logic [c_PTR_W-1:0]   w_column_low;

    // Scan offsets from the highest down so the offset nearest the pointer wins.
    always_comb begin
        w_grant       = '0;
        w_idx         = '0;
        w_any_request = 1'b0;
        for (int i = COLUMNS - 1; i >= 0; i--) begin
            w_idx = c_PTR_W'((int'(r_pointer) + i) % COLUMNS);
            if (uart_column_scheduler_request[w_idx]) begin
                w_grant       = w_idx;
                w_any_request = 1'b1;
            end
        end
    end

    assign w_frame_end  = (int'(r_bit_count) == FRAME_BITS - 1);
    assign w_column_low = r_column[c_PTR_W-1:0];

    always_ff @(posedge uart_column_scheduler_clock) begin
        if (!uart_column_scheduler_reset_active_low) begin
            r_state     <= ST_IDLE;
            r_ack       <= '0;
            r_column    <= '0;
            r_row       <= '0;
            r_load      <= 1'b0;
            r_enable    <= 1'b0;
            r_busy      <= 1'b0;
            r_pointer   <= '0;
            r_bit_count <= '0;
            r_gap_count <= '0;
        end else begin
            r_load <= 1'b0;
            r_ack  <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_request) begin
                        r_column <= 32'(w_grant);
                        r_load   <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_enable    <= 1'b1;
                    r_row       <= '0;
                    r_bit_count <= '0;
                    r_state     <= ST_SEND;
                end
                ST_SEND: begin
                    if (w_frame_end) begin
                        r_bit_count <= '0;
                        // Ack is raised on entry so it coincides with the DONE cycle.
                        if (r_row == c_ROW_LAST) begin
                            r_enable <= 1'b0;
                            r_ack    <= c_ACK_ONE << w_column_low;
                            r_state  <= ST_DONE;
                        end else begin
                            r_row <= r_row + 1'b1;
                        end
                    end else begin
                        r_bit_count <= r_bit_count + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_pointer   <= (w_column_low == c_PTR_LAST) ? '0 : w_column_low + 1'b1;
                    r_gap_count <= '0;
                    if (GAP_CYCLES == 0) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (int'(r_gap_count) >= GAP_CYCLES - 1) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_count <= r_gap_count + 1'b1;
                    end
                end
                default: begin
                    r_enable <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign uart_column_scheduler_ack    = r_ack;
    assign uart_column_scheduler_column = r_column;
    assign uart_column_scheduler_row    = r_row;
    assign uart_column_scheduler_load   = r_load;
    assign uart_column_scheduler_enable = r_enable;
    assign uart_column_scheduler_busy   = r_busy;

`ifdef UART_COLUMN_SCHEDULER_STATS_EN
    logic [15:0] r_frames_sent;
    logic [15:0] r_wait_max;
    logic [15:0] r_wait_count [COLUMNS];
    logic        w_waiting_state;
    logic        w_granting;

    assign w_waiting_state = (r_state == ST_IDLE) || (r_state == ST_GAP);
    assign w_granting      = (r_state == ST_IDLE) && w_any_request;

    // Wait counts cover IDLE/GAP cycles spent pending before the grant cycle.
    always_ff @(posedge uart_column_scheduler_clock) begin
        if (!uart_column_scheduler_reset_active_low) begin
            r_frames_sent <= '0;
            r_wait_max    <= '0;
            for (int i = 0; i < COLUMNS; i++) begin
                r_wait_count[i] <= '0;
            end
        end else begin
            if ((r_state == ST_SEND) && w_frame_end && (r_frames_sent != 16'hFFFF)) begin
                r_frames_sent <= r_frames_sent + 16'd1;
            end
            if (w_granting && (r_wait_count[w_grant] > r_wait_max)) begin
                r_wait_max <= r_wait_count[w_grant];
            end
            for (int i = 0; i < COLUMNS; i++) begin
                if (!uart_column_scheduler_request[i]) begin
                    r_wait_count[i] <= '0;
                end else if (w_granting && (w_grant == c_PTR_W'(i))) begin
                    r_wait_count[i] <= '0;
                end else if (w_waiting_state && (r_wait_count[i] != 16'hFFFF)) begin
                    r_wait_count[i] <= r_wait_count[i] + 16'd1;
                end
            end
        end
    end

    assign uart_column_scheduler_frames_sent = r_frames_sent;
    assign uart_column_scheduler_wait_max    = r_wait_max;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_column_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : tb_uart_column_scheduler
// Brief    : Directed and randomized checks of burst timing and round-robin
//            grant order against a transaction-level reference model.
// Revision : 1.0  initial release
//==============================================================================
module tb_uart_column_scheduler;

    localparam int COLUMNS    = 4;
    localparam int ROWS       = 4;
    localparam int FRAME_BITS = 11;
    localparam int GAP_CYCLES = 2;
    localparam int BURST      = ROWS * FRAME_BITS;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [3:0]         request = 4'b0000;
    logic [3:0]         ack;
    logic signed [31:0] column;
    logic [1:0]         row;
    logic               load;
    logic               enable;
    logic               busy;

    int n_cmp = 0;
    int n_err = 0;
    int ptr   = 0;

    always #5 clk = ~clk;

    uart_column_scheduler #(
        .COLUMNS    (COLUMNS),
        .ROWS       (ROWS),
        .FRAME_BITS (FRAME_BITS),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .uart_column_scheduler_clock            (clk),
        .uart_column_scheduler_reset_active_low (rst_n),
        .uart_column_scheduler_request          (request),
        .uart_column_scheduler_ack              (ack),
        .uart_column_scheduler_column           (column),
        .uart_column_scheduler_row              (row),
        .uart_column_scheduler_load             (load),
        .uart_column_scheduler_enable           (enable),
        .uart_column_scheduler_busy             (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference arbiter: first requesting column at or above the pointer, wrapping.
    function automatic int rr_pick(input logic [3:0] req, input int p);
        for (int i = 0; i < COLUMNS; i++) begin
            if (req[(p + i) % COLUMNS]) return (p + i) % COLUMNS;
        end
        return -1;
    endfunction

    // Called in an IDLE cycle with request already driven; returns in the first IDLE cycle after the gap.
    task automatic do_burst(input logic [3:0] next_req, input bit clear_acked, input bit drop_mid);
        int         col;
        logic [3:0] nxt;
        col = rr_pick(request, ptr);
        tick();
        chk("load_pulse", 32'(load), 32'd1);
        chk("grant_column", column, 32'(col));
        chk("busy_load", 32'(busy), 32'd1);
        chk("enable_load", 32'(enable), 32'd0);
        for (int k = 0; k < BURST; k++) begin
            tick();
            chk("enable_send", 32'(enable), 32'd1);
            chk("row", 32'(row), 32'(k / FRAME_BITS));
            chk("column_stable", column, 32'(col));
            if (ack !== 4'b0000 || load !== 1'b0) chk("quiet_send", {ack, load}, 32'd0);
            if (drop_mid && k == 20) request = 4'($urandom_range(0, 15));
        end
        tick();
        chk("ack", 32'(ack), 32'(4'b0001 << col));
        chk("enable_done", 32'(enable), 32'd0);
        chk("busy_done", 32'(busy), 32'd1);
        ptr = (col + 1) % COLUMNS;
        nxt = clear_acked ? (request & ~(4'b0001 << col)) : next_req;
        request = nxt;
        tick();
        chk("ack_single_cycle", 32'(ack), 32'd0);
        chk("busy_gap1", 32'(busy), 32'd1);
        chk("load_gap", 32'(load), 32'd0);
        tick();
        chk("busy_gap2", 32'(busy), 32'd1);
        tick();
        chk("busy_idle", 32'(busy), 32'd0);
        chk("enable_idle", 32'(enable), 32'd0);
    endtask

    initial begin
        logic [3:0] nr;
        // Reset held three cycles with no requests.
        rst_n = 1'b0;
        request = 4'b0000;
        tick(); tick(); tick();
        chk("rst_column", column, 32'd0);
        chk("rst_row", 32'(row), 32'd0);
        chk("rst_load", 32'(load), 32'd0);
        chk("rst_enable", 32'(enable), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick(); tick();
        chk("idle_after_rst_busy", 32'(busy), 32'd0);
        chk("idle_after_rst_load", 32'(load), 32'd0);

        // All requests held, each acked bit dropped: grants 0,1,2,3.
        request = 4'b1111;
        for (int b = 0; b < 4; b++) do_burst(4'b0000, 1'b1, 1'b0);
        chk("rr_pointer_wrapped_idle", 32'(busy), 32'd0);

        // Single request on column 2, then all held: grants 3, 0, 1.
        request = 4'b0100;
        do_burst(4'b1111, 1'b0, 1'b0);
        do_burst(4'b1111, 1'b0, 1'b0);
        do_burst(4'b1111, 1'b0, 1'b0);
        do_burst(4'b0000, 1'b0, 1'b0);
        tick(); tick();
        chk("idle_no_load", 32'(load), 32'd0);
        chk("idle_no_busy", 32'(busy), 32'd0);

        // Randomized request patterns, some dropped mid-burst.
        request = 4'($urandom_range(1, 15));
        for (int b = 0; b < 10; b++) begin
            nr = 4'($urandom_range(0, 15));
            do_burst(nr, 1'b0, 1'($urandom_range(0, 1)));
            if (request == 4'b0000) begin
                tick(); tick();
                chk("rand_idle_load", 32'(load), 32'd0);
                request = 4'($urandom_range(1, 15));
            end
        end
        request = 4'b0000;
        tick(); tick(); tick(); tick();

        // Reset in the middle of a burst.
        request = 4'b1100;
        tick();
        chk("mid_load", 32'(load), 32'd1);
        chk("mid_column", column, 32'(rr_pick(4'b1100, ptr)));
        for (int k = 0; k < 20; k++) tick();
        chk("mid_enable_before", 32'(enable), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_enable", 32'(enable), 32'd0);
        chk("mid_rst_row", 32'(row), 32'd0);
        chk("mid_rst_column", column, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ack", 32'(ack), 32'd0);
        rst_n = 1'b1;
        ptr = 0;
        request = 4'b0000;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (ack !== 4'b0000 || busy !== 1'b0) chk("post_rst_quiet", {ack, busy}, 32'd0);
        end
        chk("post_rst_ack", 32'(ack), 32'd0);
        request = 4'b1111;
        do_burst(4'b0000, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
